// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the N-channel arbitrating mux.
package arb_mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Channel index width; a single channel still needs one bit.
  function automatic int chan_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant generation (fixed or round-robin) and the round-robin pointer.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int MODE = MODE_FIXED,
  parameter int CW   = chan_w(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic           advance,
  output logic [NCH-1:0] grant,
  output logic [CW-1:0]  gnt_idx
);

  logic [CW-1:0] ptr;
  logic          found;
  int            base;
  int            cand;

  function automatic int wrap_idx(input int b, input int k);
    int s;
    s = b + k;
    if (s >= NCH) s = s - NCH;
    return s;
  endfunction

  // Search upward from the start point with wrap; fixed mode always starts at 0.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    base    = (MODE == MODE_RR) ? int'(ptr) : 0;
    for (int k = 0; k < NCH; k++) begin
      cand = wrap_idx(base, k);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        gnt_idx     = CW'(cand);
        found       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if ((MODE == MODE_RR) && advance) begin
      ptr <= CW'(wrap_idx(int'(gnt_idx), 1));
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// N-to-1 arbitrating mux with a single registered output entry.
module arb_mux_n
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int MODE  = MODE_FIXED
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH*WIDTH-1:0]     in_data,
  input  logic [NCH-1:0]           in_valid,
  output logic [NCH-1:0]           in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [chan_w(NCH)-1:0]   out_chan
);

  localparam int CW = chan_w(NCH);

  logic [NCH-1:0]   grant;
  logic [CW-1:0]    gnt_idx;
  logic [WIDTH-1:0] sel_data_p0;
  logic             xfer_p0;
  logic [WIDTH-1:0] data_p1;
  logic [CW-1:0]    chan_p1;
  logic             vld_p1;

  rr_arbiter #(
    .NCH  (NCH),
    .MODE (MODE),
    .CW   (CW)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (in_valid),
    .advance (xfer_p0),
    .grant   (grant),
    .gnt_idx (gnt_idx)
  );

  // Slot can take a word when empty or when the held word leaves this cycle.
  assign in_ready = grant & {NCH{~rst & (~vld_p1 | out_ready)}};
  assign xfer_p0  = |(in_valid & in_ready);

  always_comb begin
    sel_data_p0 = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) sel_data_p0 = in_data[i*WIDTH +: WIDTH];
    end
  end

  // ---- p0 -> p1: output entry register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      chan_p1 <= '0;
    end else if (xfer_p0) begin
      vld_p1  <= 1'b1;
      data_p1 <= sel_data_p0;
      chan_p1 <= gnt_idx;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_chan  = chan_p1;

endmodule

// File: tb/tb_arb_mux_n.sv
// Scoreboard bench: fixed-priority, round-robin and single-channel instances.
module tb_arb_mux_n;
  import arb_mux_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  chan;
  } exp_t;

  logic clk;
  logic rst;

  logic [127:0] in_data_fix;
  logic [3:0]   in_valid_fix, in_ready_fix;
  logic [31:0]  out_data_fix;
  logic         out_valid_fix, out_ready_fix;
  logic [1:0]   out_chan_fix;

  logic [127:0] in_data_rr;
  logic [3:0]   in_valid_rr, in_ready_rr;
  logic [31:0]  out_data_rr;
  logic         out_valid_rr, out_ready_rr;
  logic [1:0]   out_chan_rr;

  logic [4:0]   in_data_one;
  logic [0:0]   in_valid_one, in_ready_one;
  logic [4:0]   out_data_one;
  logic         out_valid_one, out_ready_one;
  logic [0:0]   out_chan_one;

  exp_t q_fix[$];
  exp_t q_rr[$];
  exp_t q_one[$];

  int n_tests = 0;
  int n_fail  = 0;

  arb_mux_n #(.WIDTH(32), .NCH(4), .MODE(MODE_FIXED)) u_fix (
    .clk(clk), .rst(rst), .in_data(in_data_fix), .in_valid(in_valid_fix),
    .in_ready(in_ready_fix), .out_data(out_data_fix), .out_valid(out_valid_fix),
    .out_ready(out_ready_fix), .out_chan(out_chan_fix)
  );

  arb_mux_n #(.WIDTH(32), .NCH(4), .MODE(MODE_RR)) u_rr (
    .clk(clk), .rst(rst), .in_data(in_data_rr), .in_valid(in_valid_rr),
    .in_ready(in_ready_rr), .out_data(out_data_rr), .out_valid(out_valid_rr),
    .out_ready(out_ready_rr), .out_chan(out_chan_rr)
  );

  arb_mux_n #(.WIDTH(5), .NCH(1), .MODE(MODE_FIXED)) u_one (
    .clk(clk), .rst(rst), .in_data(in_data_one), .in_valid(in_valid_one),
    .in_ready(in_ready_one), .out_data(out_data_one), .out_valid(out_valid_one),
    .out_ready(out_ready_one), .out_chan(out_chan_one)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output word must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid_fix && out_ready_fix) begin
      if (q_fix.size() == 0) check("fix_unexpected_word", 64'd1, 64'd0);
      else begin
        e = q_fix.pop_front();
        check("fix_data", out_data_fix, e.data);
        check("fix_chan", out_chan_fix, e.chan);
      end
    end
    if (out_valid_rr && out_ready_rr) begin
      if (q_rr.size() == 0) check("rr_unexpected_word", 64'd1, 64'd0);
      else begin
        e = q_rr.pop_front();
        check("rr_data", out_data_rr, e.data);
        check("rr_chan", out_chan_rr, e.chan);
      end
    end
    if (out_valid_one && out_ready_one) begin
      if (q_one.size() == 0) check("one_unexpected_word", 64'd1, 64'd0);
      else begin
        e = q_one.pop_front();
        check("one_data", out_data_one, e.data);
        check("one_chan", out_chan_one, e.chan);
      end
    end
  end

  initial begin
    exp_t dummy;
    rst = 1'b0;
    in_data_fix = '0; in_valid_fix = '0; out_ready_fix = 1'b1;
    in_data_rr  = '0; in_valid_rr  = '0; out_ready_rr  = 1'b1;
    in_data_one = '0; in_valid_one = '0; out_ready_one = 1'b1;

    // Reset state, with requests present to prove in_ready is gated.
    #1 rst = 1'b1;
    in_valid_fix = 4'b1111;
    #1;
    check("rst_out_valid", out_valid_fix, 0);
    check("rst_out_data", out_data_fix, 0);
    check("rst_out_chan", out_chan_fix, 0);
    check("rst_in_ready", in_ready_fix, 0);
    check("rst_one_valid", out_valid_one, 0);
    in_valid_fix = 4'b0000;
    tick();
    rst = 1'b0;
    tick();

    // Fixed priority: channel 1 always beats channel 3.
    for (int k = 0; k < 6; k++) begin
      in_valid_fix = 4'b1010;
      in_data_fix[32 +: 32] = 32'h1000_0000 + k;
      in_data_fix[96 +: 32] = 32'h3000_0000 + k;
      q_fix.push_back('{data: 32'h1000_0000 + k, chan: 4'd1});
      @(negedge clk);
      check("fix_in_ready", in_ready_fix, 4'b0010);
      tick();
    end
    in_valid_fix = 4'b0000;
    tick();
    tick();

    // Backpressure: word held three cycles, next word the cycle after release.
    out_ready_fix = 1'b0;
    in_valid_fix = 4'b0001;
    in_data_fix[0 +: 32] = 32'hAAAA_0000;
    q_fix.push_back('{data: 32'hAAAA_0000, chan: 4'd0});
    tick();
    in_data_fix[0 +: 32] = 32'hBBBB_0000;
    q_fix.push_back('{data: 32'hBBBB_0000, chan: 4'd0});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_hold_data", out_data_fix, 32'hAAAA_0000);
      check("bp_hold_valid", out_valid_fix, 1);
      check("bp_in_ready", in_ready_fix, 0);
      tick();
    end
    out_ready_fix = 1'b1;
    @(negedge clk);
    check("bp_release_ready", in_ready_fix, 4'b0001);
    tick();
    in_valid_fix = 4'b0000;
    check("bp_next_word", out_data_fix, 32'hBBBB_0000);
    tick();
    tick();

    // Round-robin rotation with all channels requesting.
    for (int i = 0; i < 4; i++) in_data_rr[i*32 +: 32] = 32'hC0DE_0000 + i;
    in_valid_rr = 4'b1111;
    q_rr.push_back('{data: 32'hC0DE_0000, chan: 4'd0}); tick();
    q_rr.push_back('{data: 32'hC0DE_0001, chan: 4'd1}); tick();
    q_rr.push_back('{data: 32'hC0DE_0002, chan: 4'd2}); tick();
    q_rr.push_back('{data: 32'hC0DE_0003, chan: 4'd3}); tick();
    q_rr.push_back('{data: 32'hC0DE_0000, chan: 4'd0}); tick();
    // Pointer now 1; grant channel 2 to move it to 3, then wrap and skip.
    in_valid_rr = 4'b0100;
    q_rr.push_back('{data: 32'hC0DE_0002, chan: 4'd2}); tick();
    in_valid_rr = 4'b0101;
    q_rr.push_back('{data: 32'hC0DE_0000, chan: 4'd0});
    @(negedge clk);
    check("rr_wrap_grant0", in_ready_rr, 4'b0001);
    tick();
    q_rr.push_back('{data: 32'hC0DE_0002, chan: 4'd2});
    @(negedge clk);
    check("rr_skip_grant2", in_ready_rr, 4'b0100);
    tick();
    in_valid_rr = 4'b0000;
    tick();
    tick();

    // Single channel, 5-bit stream: plain one-cycle register slice.
    in_valid_one = 1'b1;
    for (int k = 0; k < 32; k++) begin
      in_data_one = 5'(k);
      q_one.push_back('{data: 32'(k), chan: 4'd0});
      tick();
    end
    in_valid_one = 1'b0;
    tick();
    tick();

    // Asynchronous reset in the middle of a round-robin burst (pointer is 3).
    in_valid_rr = 4'b1111;
    q_rr.push_back('{data: 32'hC0DE_0003, chan: 4'd3}); tick();
    q_rr.push_back('{data: 32'hC0DE_0000, chan: 4'd0}); tick();
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid_rr, 0);
    check("mid_rst_data", out_data_rr, 0);
    check("mid_rst_chan", out_chan_rr, 0);
    check("mid_rst_in_ready", in_ready_rr, 0);
    check("mid_rst_fix_data", out_data_fix, 0);
    check("mid_rst_one_data", out_data_one, 0);
    dummy = q_rr.pop_back();
    @(negedge clk);
    check("mid_rst_still_empty", out_valid_rr, 0);
    #1 rst = 1'b0;
    q_rr.push_back('{data: 32'hC0DE_0000, chan: 4'd0});
    tick();
    check("post_rst_accept", out_valid_rr, 1);
    check("post_rst_ptr0", out_chan_rr, 0);
    in_valid_rr = 4'b0000;
    tick();
    tick();

    check("fix_queue_drained", q_fix.size(), 0);
    check("rr_queue_drained", q_rr.size(), 0);
    check("one_queue_drained", q_one.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_mux_n.md
ARB_MUX_N -- requirements
Module: arb_mux_n

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per channel.
REQ-002 SHALL have parameter NCH, default 4, input channel count, legal range 1..16.
REQ-003 SHALL have parameter MODE, default MODE_FIXED, arbitration mode: MODE_FIXED (lowest index wins) or MODE_RR (round-robin).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid  input  NCH  per-channel request.
REQ-008 SHALL have port in_ready  output  NCH  per-channel accept.
REQ-009 SHALL have port out_data  output  WIDTH  registered selected data.
REQ-010 SHALL have port out_valid  output  1  out_data holds an entry.
REQ-011 SHALL have port out_ready  input  1  downstream accept.
REQ-012 SHALL have port out_chan  output  max(1,$clog2(NCH))  index of the channel that supplied out_data.

Function
REQ-013 SHALL hold one output entry; state EMPTY when out_valid=0, FULL when out_valid=1.
REQ-014 SHALL compute a one-hot grant combinationally from in_valid and the priority pointer; grant is all-zero when in_valid=0.
REQ-015 SHALL drive in_ready[i] = grant[i] AND (EMPTY OR out_ready); at most one in_ready bit is high per cycle.
REQ-016 SHALL, on transfer (in_valid[i] AND in_ready[i]), load out_data=channel i data, out_chan=i, out_valid=1 at the next rising edge; latency is 1 cycle.
REQ-017 SHALL, when FULL and out_ready=1 with no transfer, clear out_valid at the next edge; out_data and out_chan hold their values.
REQ-018 SHALL, when FULL and out_ready=1 with a transfer in the same cycle, replace the entry and keep out_valid=1, giving one word per cycle sustained throughput.
REQ-019 SHALL, when FULL and out_ready=0, hold out_data, out_chan and out_valid stable and drive in_ready all-zero.
REQ-020 SHALL, in MODE_FIXED, grant the lowest-index valid channel.
REQ-021 SHALL, in MODE_RR, grant the first valid channel at or after pointer ptr, searching upward with wrap from NCH-1 to 0.
REQ-022 SHALL, in MODE_RR, set ptr = (i+1) mod NCH after a transfer from channel i; ptr is unchanged in cycles with no transfer.
REQ-023 SHALL, for NCH=1, reduce to a one-entry register slice with out_chan constant 0.
REQ-024 SHALL make in_ready independent of out_data and out_chan; no combinational path from in_data to any output.
REQ-025 SHALL make grant independent of in_data.

Reset
REQ-026 SHALL, while rst=1, force out_valid=0, out_data=0, out_chan=0, ptr=0, asynchronously and irrespective of clk.
REQ-027 SHALL drive in_ready all-zero while rst=1.
REQ-028 SHALL discard any entry held when rst asserts mid-operation; no transfer is credited in that cycle.
REQ-029 SHALL accept transfers from the first rising edge after rst deasserts.

Structure
REQ-030 SHALL take MODE_FIXED=0, MODE_RR=1 and a clog2-based channel-index width function from shared package arb_mux_pkg.
REQ-031 SHALL place grant generation and ptr in one sub-module, rr_arbiter, parametrised by NCH and MODE; the output register stays in arb_mux_n.

Verification
REQ-032 SHALL verify reset: assert rst mid-transfer with out_valid=1 -> out_valid=0, out_data=0, out_chan=0 immediately, with no clock edge.
REQ-033 SHALL verify fixed priority: MODE_FIXED, NCH=4, in_valid=4'b1010, out_ready=1 -> out_chan=1 on every cycle; channel 3 starves.
REQ-034 SHALL verify round-robin: MODE_RR, NCH=4, in_valid=4'b1111 held, out_ready=1 -> out_chan sequence 0,1,2,3,0, one per cycle.
REQ-035 SHALL verify backpressure: out_ready=0 for 3 cycles while FULL -> out_data stable and in_ready=0; release -> next word the cycle after.
REQ-036 SHALL verify wrap and skip: MODE_RR, ptr=3, in_valid=4'b0101 -> grant channel 0, then channel 2.
REQ-037 SHALL verify degenerate width: NCH=1, WIDTH=5, stream 0x00..0x1F -> output equals input delayed one cycle, no loss.
